// File: rtl/coproc_csr_pkg.sv
// Shared constants for the coprocessor CSR bank: register map, bit positions,
// run-state encoding and the default VERSION word.
package coproc_csr_pkg;
   localparam int ADDR_CTRL    = 0;
   localparam int ADDR_CMD     = 1;
   localparam int ADDR_STATUS  = 2;
   localparam int ADDR_IRQ_EN  = 3;
   localparam int ADDR_CYCLES  = 4;
   localparam int ADDR_VERSION = 5;

   localparam int CMD_START = 0;
   localparam int CMD_ABORT = 1;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_TIMEOUT = 3;

   localparam int IRQ_DONE    = 0;
   localparam int IRQ_ERR     = 1;
   localparam int IRQ_TIMEOUT = 2;

   localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_state_e;
endpackage

// File: rtl/coproc_csr_bank_if.sv
// HPS lightweight-bus slave port of the coprocessor CSR bank.
interface coproc_csr_bank_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write;
   logic              read;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, chipselect, write, read, writedata, input readdata);
   modport slave  (input address, chipselect, write, read, writedata, output readdata);
endinterface

// File: rtl/coproc_csr_bank_bus_sync_edge.sv
// Synchroniser for an asynchronous bus strobe plus its companion fields,
// with a single-cycle rising-edge indication aligned to the synced fields.
module bus_sync_edge #(
   parameter int STAGES = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              strobe,
   input  logic [DATA_W-1:0] data,
   output logic              rise,
   output logic [DATA_W-1:0] data_sync
);
   // strobe_q[STAGES] is the history flop used only for edge detection
   logic [STAGES:0]   strobe_q;
   logic [DATA_W-1:0] data_q [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         strobe_q  <= {strobe_q[STAGES-1:0], strobe};
         data_q[0] <= data;
         for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
      end
   end

   assign rise      = strobe_q[STAGES-1] & ~strobe_q[STAGES];
   assign data_sync = data_q[STAGES-1];
endmodule

// File: rtl/coproc_csr_bank.sv
// Control/status register bank for the image-scaling coprocessor.
// Optional watchdog enabled by defining TIMEOUT_EN.
module coproc_csr_bank
   import coproc_csr_pkg::*;
#(
   parameter int          DATA_W         = 32,
   parameter int          ADDR_W         = 3,
   parameter int          ALG_W          = 2,
   parameter int          ZOOM_W         = 3,
   parameter int          ZOOM_RESET     = 2,
   parameter int          SYNC_STAGES    = 2,
   parameter logic [31:0] VERSION        = VERSION_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 2**20
) (
   input  logic               clk,
   input  logic               reset,
   coproc_csr_bank_if.slave   bus,
   output logic [ALG_W-1:0]   algorithm_select_out,
   output logic [ZOOM_W-1:0]  zoom_level_out,
   output logic               start_pulse_out,
   output logic               abort_pulse_out,
   output logic               busy_out,
   output logic               irq_out,
   input  logic               processing_done_in
);
   localparam int SW = 1 + ADDR_W + DATA_W;
`ifdef TIMEOUT_EN
   localparam logic [2:0] IRQ_WMASK = 3'b111;
`else
   localparam logic [2:0] IRQ_WMASK = 3'b011;
`endif

   if (DATA_W < 16 || ADDR_W < 3 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("coproc_csr_bank: parameter out of range");
   end

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   run_state_e        state, state_n;
   logic              wr_rise, c_cs, commit, unused_wdata;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata, run_cnt, cycles, rd_mux;
   logic [SW-1:0]     wr_sync;
   logic              wr_ctrl, wr_cmd, wr_status, wr_irq, start_cmd, abort_cmd;
   logic              start_n, abort_n, done_set, err_set, to_set, cyc_load, to_hit;
   logic              done_st, err_st, to_st, pdone_q, done_rise;
   logic [2:0]        irq_en;

   bus_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(SW)) u_wr_sync (
      .clk       (clk),
      .reset     (reset),
      .strobe    (bus.write),
      .data      ({bus.chipselect, bus.address, bus.writedata}),
      .rise      (wr_rise),
      .data_sync (wr_sync)
   );

   assign {c_cs, c_addr, c_wdata} = wr_sync;
   assign unused_wdata = ^c_wdata;
   assign commit    = wr_rise & c_cs;
   assign wr_ctrl   = commit && (c_addr == ADDR_W'(ADDR_CTRL));
   assign wr_cmd    = commit && (c_addr == ADDR_W'(ADDR_CMD));
   assign wr_status = commit && (c_addr == ADDR_W'(ADDR_STATUS));
   assign wr_irq    = commit && (c_addr == ADDR_W'(ADDR_IRQ_EN));
   assign start_cmd = wr_cmd & c_wdata[CMD_START];
   assign abort_cmd = wr_cmd & c_wdata[CMD_ABORT];
   assign done_rise = processing_done_in & ~pdone_q;
   assign busy_out  = (state == RUN);

`ifdef TIMEOUT_EN
   assign to_hit = (state == RUN) && (run_cnt == DATA_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Abort (including start+abort) outranks completion; start during RUN only flags err
   always_comb begin
      state_n  = state;
      start_n  = 1'b0;
      abort_n  = 1'b0;
      done_set = 1'b0;
      to_set   = 1'b0;
      cyc_load = 1'b0;
      err_set  = (state == RUN) && start_cmd && !abort_cmd;
      unique case (state)
         IDLE: if (start_cmd && !abort_cmd) begin
            state_n = RUN;
            start_n = 1'b1;
         end
         RUN: if (abort_cmd) begin
            state_n = IDLE;
            abort_n = 1'b1;
         end else if (done_rise) begin
            state_n  = IDLE;
            done_set = 1'b1;
            cyc_load = 1'b1;
         end else if (to_hit) begin
            state_n = IDLE;
            abort_n = 1'b1;
            to_set  = 1'b1;
         end
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_W'(ADDR_CTRL): begin
            rd_mux[ALG_W-1:0]              = algorithm_select_out;
            rd_mux[ALG_W+ZOOM_W-1:ALG_W]   = zoom_level_out;
         end
         ADDR_W'(ADDR_STATUS):  rd_mux[3:0] = {to_st, err_st, done_st, busy_out};
         ADDR_W'(ADDR_IRQ_EN):  rd_mux[2:0] = irq_en;
         ADDR_W'(ADDR_CYCLES):  rd_mux = cycles;
         ADDR_W'(ADDR_VERSION): rd_mux = DATA_W'(VERSION);
         default: ;
      endcase
   end

   // Hardware set is OR-ed after the W1C mask so a simultaneous set wins
   always_ff @(posedge clk) begin
      if (reset) begin
         start_pulse_out      <= 1'b0;
         abort_pulse_out      <= 1'b0;
         algorithm_select_out <= '0;
         zoom_level_out       <= ZOOM_W'(ZOOM_RESET);
         irq_en               <= '0;
         done_st              <= 1'b0;
         err_st               <= 1'b0;
         run_cnt              <= '0;
         cycles               <= '0;
         pdone_q              <= 1'b0;
         irq_out              <= 1'b0;
         bus.readdata         <= '0;
      end else begin
         start_pulse_out <= start_n;
         abort_pulse_out <= abort_n;
         if (wr_ctrl) begin
            algorithm_select_out <= c_wdata[ALG_W-1:0];
            zoom_level_out       <= c_wdata[ALG_W+ZOOM_W-1:ALG_W];
         end
         if (wr_irq) irq_en <= c_wdata[2:0] & IRQ_WMASK;
         done_st <= (done_st & ~(wr_status & c_wdata[STAT_DONE])) | done_set;
         err_st  <= (err_st  & ~(wr_status & c_wdata[STAT_ERR]))  | err_set;
         if (start_n)            run_cnt <= '0;
         else if (state == RUN)  run_cnt <= sat_inc(run_cnt);
         if (cyc_load) cycles <= sat_inc(run_cnt);
         pdone_q <= processing_done_in;
         irq_out <= |({to_st, err_st, done_st} & irq_en);
         if (bus.chipselect && bus.read) bus.readdata <= rd_mux;
      end
   end

`ifdef TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) to_st <= 1'b0;
      else       to_st <= (to_st & ~(wr_status & c_wdata[STAT_TIMEOUT])) | to_set;
   end
`else
   assign to_st = 1'b0;
`endif
endmodule

// File: tb/tb_coproc_csr_bank.sv
// Directed bench for coproc_csr_bank: register map, write sync timing, run FSM,
// sticky status, interrupt and reset behaviour.
module tb_coproc_csr_bank;
   import coproc_csr_pkg::*;

   localparam int SYNC = 2;
`ifdef TIMEOUT_EN
   localparam int RUN_LEN = 10;
`else
   localparam int RUN_LEN = 40;
`endif

   logic clk, reset, processing_done_in;
   logic [1:0] algorithm_select_out;
   logic [2:0] zoom_level_out;
   logic start_pulse_out, abort_pulse_out, busy_out, irq_out;
   int vectors, miscompares, start_seen, abort_seen;

   coproc_csr_bank_if #(.ADDR_W(3), .DATA_W(32)) bus ();

   coproc_csr_bank #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(16)) dut (
      .clk                  (clk),
      .reset                (reset),
      .bus                  (bus),
      .algorithm_select_out (algorithm_select_out),
      .zoom_level_out       (zoom_level_out),
      .start_pulse_out      (start_pulse_out),
      .abort_pulse_out      (abort_pulse_out),
      .busy_out             (busy_out),
      .irq_out              (irq_out),
      .processing_done_in   (processing_done_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input int hold);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write = 1'b1;
      for (int i = 0; i < hold + SYNC + 3; i++) begin
         @(posedge clk); #1;
         if (i == hold - 1) begin bus.write = 1'b0; bus.chipselect = 1'b0; end
         if (start_pulse_out) start_seen++;
         if (abort_pulse_out) abort_seen++;
      end
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.address = a; bus.chipselect = 1'b1; bus.read = 1'b1;
      @(posedge clk); #1;
      d = bus.readdata;
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      vectors++; if (bus.readdata !== 32'h0) begin miscompares++; $display("FAIL rst_readdata: got %0h want 0", bus.readdata); end
      vectors++; if (zoom_level_out !== 3'd2 || algorithm_select_out !== 2'd0) begin miscompares++; $display("FAIL rst_ctrl: got zoom %0d alg %0d want 2/0", zoom_level_out, algorithm_select_out); end
      vectors++; if ({start_pulse_out, abort_pulse_out, busy_out, irq_out} !== 4'b0) begin miscompares++; $display("FAIL rst_outs: got %b want 0000", {start_pulse_out, abort_pulse_out, busy_out, irq_out}); end
      bus_read(3'(ADDR_CTRL), rd);
      vectors++; if (rd !== 32'h8) begin miscompares++; $display("FAIL rst_rd_ctrl: got %0h want 8", rd); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_rd_status: got %0h want 0", rd); end
      bus_read(3'(ADDR_VERSION), rd);
      vectors++; if (rd !== 32'h0002_0000) begin miscompares++; $display("FAIL rst_rd_version: got %0h want 20000", rd); end
      bus_read(3'd7, rd);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rd_unmapped: got %0h want 0", rd); end
   endtask

   task automatic test_ctrl_write();
      logic [31:0] rd;
      bus.address = 3'(ADDR_CTRL); bus.writedata = 32'h0D; bus.chipselect = 1'b1; bus.write = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (algorithm_select_out !== 2'd0) begin miscompares++; $display("FAIL ctrl_early: got alg %0d want 0", algorithm_select_out); end
      @(posedge clk); #1;
      vectors++; if (algorithm_select_out !== 2'd1 || zoom_level_out !== 3'd3) begin miscompares++; $display("FAIL ctrl_update: got alg %0d zoom %0d want 1/3", algorithm_select_out, zoom_level_out); end
      repeat (2) @(posedge clk);
      #1 bus.write = 1'b0; bus.chipselect = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus_read(3'(ADDR_CTRL), rd);
      vectors++; if (rd !== 32'h0D) begin miscompares++; $display("FAIL ctrl_readback: got %0h want d", rd); end
   endtask

   task automatic test_start_done();
      logic [31:0] rd;
      int pulses, busy_cnt, seen;
      bus_write(3'(ADDR_IRQ_EN), 32'h1, 1);
      pulses = 0; busy_cnt = 0; seen = -1;
      bus.address = 3'(ADDR_CMD); bus.writedata = 32'h1; bus.chipselect = 1'b1; bus.write = 1'b1;
      for (int i = 0; i < RUN_LEN + 20; i++) begin
         @(posedge clk); #1;
         if (i == 4) begin bus.write = 1'b0; bus.chipselect = 1'b0; end
         if (start_pulse_out) begin pulses++; if (seen < 0) seen = i; end
         if (busy_out) busy_cnt++;
         if (seen >= 0 && i == seen + RUN_LEN - 1) processing_done_in = 1'b1;
         if (seen >= 0 && i == seen + RUN_LEN) break;
      end
      vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL start_pulses: got %0d want 1", pulses); end
      vectors++; if (busy_cnt !== RUN_LEN) begin miscompares++; $display("FAIL busy_len: got %0d want %0d", busy_cnt, RUN_LEN); end
      vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq_out); end
      @(posedge clk); #1;
      processing_done_in = 1'b0;
      vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("FAIL irq_done: got %b want 1", irq_out); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL status_done: got %0h want 2", rd); end
      bus_read(3'(ADDR_CYCLES), rd);
      vectors++; if (rd !== 32'(RUN_LEN)) begin miscompares++; $display("FAIL cycles: got %0d want %0d", rd, RUN_LEN); end
      bus_write(3'(ADDR_STATUS), 32'h2, 1);
      vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL irq_w1c: got %b want 0", irq_out); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL status_w1c: got %0h want 0", rd); end
   endtask

   task automatic test_err_abort();
      logic [31:0] rd;
      start_seen = 0; abort_seen = 0;
      bus_write(3'(ADDR_CMD), 32'h1, 1);
      vectors++; if (start_seen !== 1 || busy_out !== 1'b1) begin miscompares++; $display("FAIL run_start: got pulses %0d busy %b want 1/1", start_seen, busy_out); end
      start_seen = 0;
      bus_write(3'(ADDR_CMD), 32'h1, 1);
      vectors++; if (start_seen !== 0) begin miscompares++; $display("FAIL restart_pulse: got %0d want 0", start_seen); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL status_err: got %0h want 5", rd); end
      bus_write(3'(ADDR_CMD), 32'h3, 1);
      vectors++; if (abort_seen !== 1 || busy_out !== 1'b0 || start_seen !== 0) begin miscompares++; $display("FAIL abort: got aborts %0d busy %b starts %0d want 1/0/0", abort_seen, busy_out, start_seen); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h4) begin miscompares++; $display("FAIL status_abort: got %0h want 4", rd); end
      abort_seen = 0;
      bus_write(3'(ADDR_CMD), 32'h3, 1);
      vectors++; if (abort_seen !== 0 || start_seen !== 0 || busy_out !== 1'b0) begin miscompares++; $display("FAIL idle_both: got aborts %0d starts %0d busy %b want 0/0/0", abort_seen, start_seen, busy_out); end
      bus_write(3'(ADDR_STATUS), 32'h4, 1);
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL err_w1c: got %0h want 0", rd); end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] rd;
      bus_write(3'(ADDR_CMD), 32'h1, 1);
      bus.address = 3'(ADDR_STATUS); bus.writedata = 32'h2; bus.chipselect = 1'b1; bus.write = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      processing_done_in = 1'b1;
      @(posedge clk); #1;
      bus.write = 1'b0; bus.chipselect = 1'b0;
      repeat (3) @(posedge clk);
      #1 processing_done_in = 1'b0;
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL set_beats_w1c: got %0h want 2", rd); end
      bus_write(3'(ADDR_STATUS), 32'h2, 1);
   endtask

`ifdef TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd;
      int seen, dist;
      seen = -1; dist = -1;
      bus.address = 3'(ADDR_CMD); bus.writedata = 32'h1; bus.chipselect = 1'b1; bus.write = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin bus.write = 1'b0; bus.chipselect = 1'b0; end
         if (start_pulse_out && seen < 0) seen = i;
         if (abort_pulse_out && seen >= 0 && dist < 0) dist = i - seen;
      end
      vectors++; if (dist !== 16) begin miscompares++; $display("FAIL timeout_dist: got %0d want 16", dist); end
      bus_read(3'(ADDR_STATUS), rd);
      vectors++; if (rd !== 32'h8) begin miscompares++; $display("FAIL status_timeout: got %0h want 8", rd); end
      bus_write(3'(ADDR_STATUS), 32'h8, 1);
   endtask
`endif

   task automatic test_reset_mid_run();
      logic [31:0] rd;
      bus_write(3'(ADDR_CTRL), 32'h1F, 1);
      bus_write(3'(ADDR_CMD), 32'h1, 1);
      bus_read(3'(ADDR_VERSION), rd);
      vectors++; if (busy_out !== 1'b1 || rd !== 32'h0002_0000) begin miscompares++; $display("FAIL pre_reset: got busy %b rd %0h want 1/20000", busy_out, rd); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if ({start_pulse_out, abort_pulse_out, busy_out, irq_out} !== 4'b0) begin miscompares++; $display("FAIL mid_reset_outs: got %b want 0000", {start_pulse_out, abort_pulse_out, busy_out, irq_out}); end
      vectors++; if (algorithm_select_out !== 2'd0 || zoom_level_out !== 3'd2 || bus.readdata !== 32'h0) begin miscompares++; $display("FAIL mid_reset_regs: got alg %0d zoom %0d rd %0h want 0/2/0", algorithm_select_out, zoom_level_out, bus.readdata); end
      bus_read(3'(ADDR_CYCLES), rd);
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mid_reset_cycles: got %0h want 0", rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vectors = 0; miscompares = 0; start_seen = 0; abort_seen = 0;
      reset = 1'b1; processing_done_in = 1'b0;
      bus.address = '0; bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;
      test_reset();
      test_ctrl_write();
      test_start_done();
      test_err_abort();
      test_w1c_collision();
`ifdef TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
